// File: rtl/traceback_unit.sv
// traceback_unit: survivor memory and traceback for the 8-state (K=4) rate-1/2 Viterbi decoder.
// Latency: first bits 2L cycles after the 2L-th column, then every L columns; L bits out per block.
// Backpressure: dec_ready low through trace and output; out_bit/out_valid held while out_ready=0.
module traceback_unit #(
  parameter int L = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] decision,
  input  logic       dec_valid,
  output logic       dec_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int DEPTH = 2 * L;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(L);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WRITE,
    ST_TRACE,
    ST_OUTPUT
  } state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   step_q;
  logic [CW-1:0]   col_cnt_q;
  logic [OW-1:0]   out_idx_q;
  logic [2:0]      s_q;
  logic [L-1:0]    obuf_q;
  logic            dec_ready_q;
  logic            out_valid_q;
  logic            out_bit_q;

  logic            accept;
  logic [7:0]      rd_col;
  logic [2:0]      s_d;
  logic [OW-1:0]   slot;
  logic [CW-1:0]   col_cnt_d;
  logic [OW-1:0]   out_idx_d;
  logic            blk_done;
  logic            out_hs;
  logic            out_last;
  logic            decode_step;

  // dec_ready is only high in FILL/WRITE, so this is the column-accept strobe
  assign accept      = dec_valid & dec_ready_q;
  // Survivor memory read is combinational; one trellis step per trace cycle
  assign rd_col      = mem_q[rd_ptr_q];
  assign s_d         = {s_q[1:0], rd_col[s_q]};
  // Steps L..2L-1 decode; step L is the newest decoded column, so it lands in the last slot
  assign decode_step = step_q[PW-1];
  assign slot        = ~step_q[OW-1:0];
  assign col_cnt_d   = col_cnt_q + CW'(1);
  assign blk_done    = (state_q == ST_FILL) ? (col_cnt_d == CW'(DEPTH)) : (col_cnt_d == CW'(L));
  assign out_hs      = out_valid_q & out_ready;
  assign out_last    = (out_idx_q == OW'(L - 1));
  assign out_idx_d   = out_idx_q + OW'(1);

  // Store each accepted decision column at the write pointer; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= decision;
    end
  end

  // Capture decoded bits during the second half of the trace, indexed oldest-first
  always_ff @(posedge clk) begin
    if (state_q == ST_TRACE && decode_step) begin
      obuf_q[slot] <= s_q[2];
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      step_q      <= '0;
      col_cnt_q   <= '0;
      out_idx_q   <= '0;
      s_q         <= '0;
      dec_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL, ST_WRITE: begin
          dec_ready_q <= 1'b1;
          if (accept) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            if (blk_done) begin
              // Trace starts at the column written on this edge, from state 0
              state_q     <= ST_TRACE;
              dec_ready_q <= 1'b0;
              col_cnt_q   <= '0;
              step_q      <= '0;
              s_q         <= '0;
              rd_ptr_q    <= wr_ptr_q;
            end else begin
              col_cnt_q <= col_cnt_d;
            end
          end
        end
        ST_TRACE: begin
          s_q      <= s_d;
          rd_ptr_q <= rd_ptr_q - PW'(1);
          step_q   <= step_q + PW'(1);
          if (step_q == PW'(DEPTH - 1)) begin
            // Oldest bit is being written to the buffer this edge; forward it directly
            state_q     <= ST_OUTPUT;
            out_valid_q <= 1'b1;
            out_bit_q   <= s_q[2];
            out_idx_q   <= '0;
          end
        end
        ST_OUTPUT: begin
          if (out_hs) begin
            if (out_last) begin
              state_q     <= ST_WRITE;
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_idx_q   <= '0;
              dec_ready_q <= 1'b1;
            end else begin
              out_idx_q <= out_idx_d;
              out_bit_q <= obuf_q[out_idx_d];
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign dec_ready = dec_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;

endmodule
